// File: rtl/remote_comm_pkg.sv
// Shared constants and types for the remote command link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default UART bit period, TX packet sequencer states, packet length.
package remote_comm_pkg;

    // clk cycles per UART bit period
    localparam int BAUD_DIV_DEF = 2604;

    // bytes per command packet: cmd, data[15:8], data[7:0]
    localparam int PKT_LEN = 3;

    // packet sequencer: which byte of the packet is on the wire
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        MID  = 2'd2,
        LOW  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/remote_comm_if.sv
// Host-side command/response bundle for remote_comm.
// Latency: n/a (wires only).
// Backpressure: none; send_cmd is dropped unless the sequencer is idle.
// master = host (drives cmd/data/send_cmd/clr_resp_rdy), slave = remote_comm.
interface remote_comm_if;

    logic [7:0]  cmd;           // command byte to send
    logic [15:0] data;          // data word accompanying cmd
    logic        send_cmd;      // one-cycle pulse: start a packet
    logic        cmd_sent;      // last packet has fully left TX
    logic [7:0]  resp;          // last response byte received
    logic        resp_rdy;      // new response byte available
    logic        clr_resp_rdy;  // knocks resp_rdy down

    modport master (
        output cmd, data, send_cmd, clr_resp_rdy,
        input  cmd_sent, resp, resp_rdy
    );

    modport slave (
        input  cmd, data, send_cmd, clr_resp_rdy,
        output cmd_sent, resp, resp_rdy
    );

endinterface

// File: rtl/remote_comm_uart.sv
// 8N1 byte transmitter and receiver, independent and concurrent.
// Latency: TX start bit one cycle after trmt; rx_data/rdy update at the stop-bit sample.
// Backpressure: none; trmt while busy restarts the transmitter, rdy is a sticky flag.
// Ports: trmt/tx_data -> TX, tx_done pulses in the last stop-bit cycle;
//        RX -> rx_data with rdy, cleared by clr_rdy or a new start bit.
module uart
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    input  logic       clr_rdy
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    // ---------------- transmitter ----------------
    logic [9:0]       tx_shift_q;   // {stop, data, start}, shifted out LSB first
    logic [CNT_W-1:0] tx_baud_q;
    logic [3:0]       tx_bit_q;
    logic             tx_busy_q;
    logic             tx_bit_end;

    assign tx_bit_end = tx_busy_q && (tx_baud_q == BIT_LAST);
    assign tx_done    = tx_bit_end && (tx_bit_q == 4'd9);
    // Ones shift in behind the frame, so the line idles high without extra logic.
    assign TX         = tx_shift_q[0];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_busy_q  <= 1'b0;
        end else if (trmt) begin
            // Loading on the same edge that ends the previous stop bit
            // gives back-to-back frames with no idle gap.
            tx_shift_q <= {1'b1, tx_data, 1'b0};
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_busy_q  <= 1'b1;
        end else if (tx_busy_q) begin
            if (tx_bit_end) begin
                tx_baud_q  <= '0;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_bit_q  <= '0;
                end else begin
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + CNT_W'(1);
            end
        end
    end

    // ---------------- receiver ----------------
    logic             rx_ff1_q, rx_ff2_q, rx_prev_q;
    logic             rx_busy_q;
    logic [CNT_W-1:0] rx_baud_q;
    logic [3:0]       rx_bit_q;     // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]       rx_shift_q;
    logic [7:0]       rx_data_q;
    logic             rdy_q;
    logic             rx_start;
    logic             rx_sample;
    logic             rx_done;

    assign rx_start  = !rx_busy_q && rx_prev_q && !rx_ff2_q;
    // First sample lands mid start bit, later ones a full period apart.
    assign rx_sample = rx_busy_q &&
                       (rx_baud_q == ((rx_bit_q == 4'd0) ? HALF_LAST : BIT_LAST));
    assign rx_done   = rx_sample && (rx_bit_q == 4'd9);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_ff1_q  <= 1'b1;
            rx_ff2_q  <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_ff1_q  <= RX;
            rx_ff2_q  <= rx_ff1_q;
            rx_prev_q <= rx_ff2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_busy_q  <= 1'b0;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else if (rx_start) begin
            rx_busy_q <= 1'b1;
            rx_baud_q <= '0;
            rx_bit_q  <= '0;
        end else if (rx_busy_q) begin
            if (rx_sample) begin
                rx_baud_q <= '0;
                if ((rx_bit_q == 4'd0) && rx_ff2_q) begin
                    // line back high at mid start bit: a glitch, not a frame
                    rx_busy_q <= 1'b0;
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_bit_q  <= '0;
                    rx_data_q <= rx_shift_q;
                end else begin
                    rx_bit_q <= rx_bit_q + 4'd1;
                    if (rx_bit_q != 4'd0) begin
                        rx_shift_q <= {rx_ff2_q, rx_shift_q[7:1]};
                    end
                end
            end else begin
                rx_baud_q <= rx_baud_q + CNT_W'(1);
            end
        end
    end

    // Set has priority over both clear sources.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rdy_q <= 1'b0;
        end else if (rx_done) begin
            rdy_q <= 1'b1;
        end else if (clr_rdy || rx_start) begin
            rdy_q <= 1'b0;
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;

endmodule

// File: rtl/remote_comm.sv
// Sends 3-byte command packets (cmd, data[15:8], data[7:0]) and receives response bytes.
// Latency: start bit on TX 2 cycles after send_cmd; cmd_sent 1 cycle after last stop bit.
// Backpressure: send_cmd outside IDLE is ignored; resp_rdy is sticky until cleared.
// Ports: clk, rst_n (sync, active-high), RX/TX serial lines, bus = host bundle (slave).
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         RX,
    output logic         TX,
    remote_comm_if.slave bus
);

    tx_state_e   state_q, state_d;
    logic [7:0]  cmd_q;
    logic [15:0] data_q;
    logic        launch_q;     // first byte goes out the cycle after capture
    logic        cmd_sent_q;

    logic        accept;
    logic        pkt_done;
    logic        trmt;
    logic [7:0]  tx_byte;
    logic        tx_done;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        pkt_done = 1'b0;
        trmt     = 1'b0;
        tx_byte  = cmd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.send_cmd) begin
                    accept  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (launch_q) begin
                    trmt    = 1'b1;
                    tx_byte = cmd_q;
                end else if (tx_done) begin
                    trmt    = 1'b1;
                    tx_byte = data_q[15:8];
                    state_d = MID;
                end
            end
            MID: begin
                if (tx_done) begin
                    trmt    = 1'b1;
                    tx_byte = data_q[7:0];
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tx_done) begin
                    pkt_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            data_q     <= '0;
            launch_q   <= 1'b0;
            cmd_sent_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            launch_q <= accept;
            if (accept) begin
                cmd_q      <= bus.cmd;
                data_q     <= bus.data;
                cmd_sent_q <= 1'b0;
            end else if (pkt_done) begin
                cmd_sent_q <= 1'b1;
            end
        end
    end

    uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_byte),
        .tx_done (tx_done),
        .TX      (TX),
        .RX      (RX),
        .rx_data (bus.resp),
        .rdy     (bus.resp_rdy),
        .clr_rdy (bus.clr_resp_rdy)
    );

    assign bus.cmd_sent = cmd_sent_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm with a behavioural quad-side peer on TX/RX.
// Latency: n/a. Backpressure: n/a.
// The peer decodes 8N1 packets off TX and drives response bytes onto RX.
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int BAUD = 16;
    localparam int TMO  = 20 * BAUD;

    logic clk = 1'b0;
    logic rst_n;
    logic RX;
    logic TX;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t_send = 0;

    remote_comm_if bus ();

    remote_comm #(.BAUD_DIV(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; drives one 8N1 frame onto RX.
    task automatic peer_send(input logic [7:0] b);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    // Waits for a start bit on TX, samples mid-bit; returns at mid stop bit.
    task automatic peer_get_byte(output logic [7:0] b, output int t_start, output logic ok);
        int n;
        n = 0;
        ok = 1'b1;
        b = '0;
        t_start = 0;
        while (TX !== 1'b0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (TX !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        t_start = cyc;
        repeat (BAUD / 2) @(negedge clk);
        if (TX !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        if (TX !== 1'b1) ok = 1'b0;
    endtask

    task automatic peer_get_pkt(output logic [7:0] c, output logic [15:0] d,
                                output logic ok, output int t0, output int span);
        logic [7:0] b [PKT_LEN];
        int         ts [PKT_LEN];
        logic       k;
        ok = 1'b1;
        for (int i = 0; i < PKT_LEN; i++) begin
            peer_get_byte(b[i], ts[i], k);
            if (!k) ok = 1'b0;
        end
        c    = b[0];
        d    = {b[1], b[2]};
        t0   = ts[0];
        span = ts[PKT_LEN-1] - ts[0];
    endtask

    task automatic pulse_send(input logic [7:0] c, input logic [15:0] d);
        bus.cmd      = c;
        bus.data     = d;
        bus.send_cmd = 1'b1;
        t_send       = cyc;
        @(negedge clk);
        bus.send_cmd = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int n;
        n = 0;
        while (bus.resp_rdy !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk_eq({tag, "_rdy"}, bus.resp_rdy, 1);
    endtask

    // Sends one packet while the peer decodes it; optionally changes the
    // inputs and pulses send_cmd mid-packet, which must have no effect.
    task automatic run_pkt(input logic [7:0] c, input logic [15:0] d,
                           input logic poke, input string tag);
        logic [7:0]  gc;
        logic [15:0] gd;
        logic        ok;
        int          t0, span;
        fork
            peer_get_pkt(gc, gd, ok, t0, span);
            pulse_send(c, d);
            begin
                @(negedge clk);
                chk_eq({tag, "_sent_clr"}, bus.cmd_sent, 0);
            end
            begin
                if (poke) begin
                    repeat (5 * BAUD) @(negedge clk);
                    pulse_send(8'h11, 16'h2222);
                end
            end
        join
        chk_eq({tag, "_frame"}, ok, 1);
        chk_eq({tag, "_cmd"}, gc, c);
        chk_eq({tag, "_data"}, gd, d);
        chk_eq({tag, "_lat"}, (t0 - t_send) <= 2, 1);
        chk_eq({tag, "_gap"}, span, 20 * BAUD);
        chk_eq({tag, "_sent_early"}, bus.cmd_sent, 0);
        repeat (BAUD / 2 + 1) @(negedge clk);
        chk_eq({tag, "_sent"}, bus.cmd_sent, 1);
    endtask

    initial begin
        logic [7:0]  gc;
        logic [15:0] gd;
        logic        ok;
        int          t0, span;

        rst_n            = 1'b1;
        RX               = 1'b1;
        bus.cmd          = '0;
        bus.data         = '0;
        bus.send_cmd     = 1'b0;
        bus.clr_resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_tx", TX, 1);
        chk_eq("rst_sent", bus.cmd_sent, 0);
        chk_eq("rst_resp", bus.resp, 8'h00);
        chk_eq("rst_rdy", bus.resp_rdy, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // command packets
        run_pkt(8'h00, 16'h0000, 1'b0, "p00");
        run_pkt(8'hFF, 16'hFFFF, 1'b0, "pff");
        run_pkt(8'hB7, 16'hB73C, 1'b1, "pb7");

        // responses, explicit clear between them
        peer_send(8'h00);
        wait_resp("r00");
        chk_eq("r00_val", bus.resp, 8'h00);
        bus.clr_resp_rdy = 1'b1;
        @(negedge clk);
        bus.clr_resp_rdy = 1'b0;
        chk_eq("r00_clr", bus.resp_rdy, 0);
        peer_send(8'hCD);
        wait_resp("rcd");
        chk_eq("rcd_val", bus.resp, 8'hCD);

        // a new start bit knocks resp_rdy down, resp holds until the new stop
        fork
            peer_send(8'h5A);
            begin
                repeat (BAUD) @(negedge clk);
                chk_eq("r5a_start_clr", bus.resp_rdy, 0);
                chk_eq("r5a_hold", bus.resp, 8'hCD);
            end
        join
        wait_resp("r5a");
        chk_eq("r5a_val", bus.resp, 8'h5A);

        // concurrent packet and response
        fork
            peer_get_pkt(gc, gd, ok, t0, span);
            pulse_send(8'hE5, 16'hC3B2);
            peer_send(8'h67);
        join
        chk_eq("cc_frame", ok, 1);
        chk_eq("cc_cmd", gc, 8'hE5);
        chk_eq("cc_data", gd, 16'hC3B2);
        wait_resp("cc_resp");
        chk_eq("cc_resp_val", bus.resp, 8'h67);
        repeat (BAUD) @(negedge clk);
        chk_eq("cc_sent", bus.cmd_sent, 1);

        // reset in the middle of a packet and of a reception (resp_rdy is 1 here)
        fork
            peer_send(8'hFF);
            pulse_send(8'h99, 16'h1234);
            begin
                repeat (3 * BAUD + 3) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                rst_n = 1'b0;
                chk_eq("mr_tx", TX, 1);
                chk_eq("mr_sent", bus.cmd_sent, 0);
                chk_eq("mr_rdy", bus.resp_rdy, 0);
                chk_eq("mr_resp", bus.resp, 8'h00);
            end
        join
        repeat (12 * BAUD) @(negedge clk);
        chk_eq("mr_no_partial", bus.resp_rdy, 0);
        chk_eq("mr_tx_idle", TX, 1);
        run_pkt(8'h3C, 16'hA55A, 1'b0, "pmr");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
